// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared forwarding encodings and scoreboard entry type
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef struct packed {
        logic [3:0] rd;
        logic       rf_e;
        logic       load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{rd: 4'd0, rf_e: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB destination tracking shift register
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      stall,
    input  sb_entry_t id_entry,
    output sb_entry_t ex_entry,
    output sb_entry_t mem_entry,
    output sb_entry_t wb_entry
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_entry  <= SB_BUBBLE;
            mem_entry <= SB_BUBBLE;
            wb_entry  <= SB_BUBBLE;
        end else begin
            wb_entry  <= mem_entry;
            mem_entry <= ex_entry;
            // A stalled ID instruction stays in ID, so EX receives a bubble
            ex_entry  <= stall ? SB_BUBBLE : id_entry;
        end
    end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// rtl/hazard_forwarding_unit.sv - operand forwarding selects, load-use stall and branch flush
module hazard_forwarding_unit
    import pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] id_rn,
    input  logic [3:0] id_rm,
    input  logic [3:0] id_rd,
    input  logic       id_use_rn,
    input  logic       id_use_rm,
    input  logic       id_use_rd,
    input  logic       id_rf_e,
    input  logic       id_load,
    input  logic       branch_taken,
    output logic [1:0] pa_sel,
    output logic [1:0] pb_sel,
    output logic [1:0] pd_sel,
    output logic       enable_pc,
    output logic       enable_ifid,
    output logic       cu_mux_sel,
    output logic       ifid_flush
);

    sb_entry_t id_entry;
    sb_entry_t ex_entry;
    sb_entry_t mem_entry;
    sb_entry_t wb_entry;
    logic      ex_load_hit;
    logic      stall;

    assign id_entry = '{rd: id_rd, rf_e: id_rf_e, load: id_load};

    hazard_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .id_entry  (id_entry),
        .ex_entry  (ex_entry),
        .mem_entry (mem_entry),
        .wb_entry  (wb_entry)
    );

    // Youngest producer wins; PC reads always come from the register file
    function automatic logic [1:0] fwd_select(
        input logic       use_src,
        input logic [3:0] src,
        input sb_entry_t  ex,
        input sb_entry_t  mem,
        input sb_entry_t  wb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && src != REG_PC) begin
            if (ex.rf_e && ex.rd == src)
                sel = FWD_EX;
            else if (mem.rf_e && mem.rd == src)
                sel = FWD_MEM;
            else if (wb.rf_e && wb.rd == src)
                sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        ex_load_hit = 1'b0;
        if (ex_entry.load && ex_entry.rf_e) begin
            ex_load_hit = (id_use_rn && id_rn == ex_entry.rd) ||
                          (id_use_rm && id_rm == ex_entry.rd) ||
                          (id_use_rd && id_rd == ex_entry.rd);
        end
    end

    assign stall = ex_load_hit && !reset;

    always_comb begin
        pa_sel      = FWD_RF;
        pb_sel      = FWD_RF;
        pd_sel      = FWD_RF;
        enable_pc   = 1'b1;
        enable_ifid = 1'b1;
        cu_mux_sel  = 1'b0;
        ifid_flush  = 1'b0;
        if (!reset) begin
            pa_sel      = fwd_select(id_use_rn, id_rn, ex_entry, mem_entry, wb_entry);
            pb_sel      = fwd_select(id_use_rm, id_rm, ex_entry, mem_entry, wb_entry);
            pd_sel      = fwd_select(id_use_rd, id_rd, ex_entry, mem_entry, wb_entry);
            enable_pc   = !stall;
            enable_ifid = !stall;
            cu_mux_sel  = stall;
            ifid_flush  = branch_taken && !stall;
        end
    end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// tb/tb_hazard_forwarding_unit.sv - directed checks of forwarding, stall, flush and reset
module tb_hazard_forwarding_unit;

    logic       clk;
    logic       reset;
    logic [3:0] id_rn;
    logic [3:0] id_rm;
    logic [3:0] id_rd;
    logic       id_use_rn;
    logic       id_use_rm;
    logic       id_use_rd;
    logic       id_rf_e;
    logic       id_load;
    logic       branch_taken;
    logic [1:0] pa_sel;
    logic [1:0] pb_sel;
    logic [1:0] pd_sel;
    logic       enable_pc;
    logic       enable_ifid;
    logic       cu_mux_sel;
    logic       ifid_flush;

    int total;
    int bad;

    hazard_forwarding_unit dut (
        .clk          (clk),
        .reset        (reset),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rd        (id_rd),
        .id_use_rn    (id_use_rn),
        .id_use_rm    (id_use_rm),
        .id_use_rd    (id_use_rd),
        .id_rf_e      (id_rf_e),
        .id_load      (id_load),
        .branch_taken (branch_taken),
        .pa_sel       (pa_sel),
        .pb_sel       (pb_sel),
        .pd_sel       (pd_sel),
        .enable_pc    (enable_pc),
        .enable_ifid  (enable_ifid),
        .cu_mux_sel   (cu_mux_sel),
        .ifid_flush   (ifid_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input logic urn, input logic urm, input logic urd,
                         input logic rfe, input logic ld, input logic br);
        id_rn        = rn;
        id_rm        = rm;
        id_rd        = rd;
        id_use_rn    = urn;
        id_use_rm    = urm;
        id_use_rd    = urd;
        id_rf_e      = rfe;
        id_load      = ld;
        branch_taken = br;
        #1;
    endtask

    task automatic issue(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input logic urn, input logic urm, input logic urd,
                         input logic rfe, input logic ld, input logic br);
        @(negedge clk);
        apply(rn, rm, rd, urn, urm, urd, rfe, ld, br);
    endtask

    task automatic check_ctl(input string tag, input logic stalled);
        check({tag, "_en_pc"},   8'(enable_pc),   stalled ? 8'd0 : 8'd1);
        check({tag, "_en_ifid"}, 8'(enable_ifid), stalled ? 8'd0 : 8'd1);
        check({tag, "_cu_mux"},  8'(cu_mux_sel),  stalled ? 8'd1 : 8'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        apply(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        // Outputs forced while in reset, even with a branch pending
        issue(4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_flush", 8'(ifid_flush), 8'd0);
        check("rst_pa", 8'(pa_sel), 8'd0);
        check_ctl("rst", 1'b0);

        // A: ADD R1 with empty scoreboard
        @(negedge clk);
        reset = 1'b0;
        apply(4'd2, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("a_pa", 8'(pa_sel), 8'd0);
        check("a_pb", 8'(pb_sel), 8'd0);
        // B: reads R1 from EX, writes R4
        issue(4'd1, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("b_pa_ex", 8'(pa_sel), 8'd1);
        check_ctl("b", 1'b0);
        // C: rm=R1 one instruction later, from MEM
        issue(4'd0, 4'd1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("c_pb_mem", 8'(pb_sel), 8'd2);
        // D: rm=R1 two instructions later, from WB; R4 from MEM via pd
        issue(4'd0, 4'd1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("d_pb_wb", 8'(pb_sel), 8'd3);
        check("d_pd_mem", 8'(pd_sel), 8'd2);
        // E: R1 has retired
        issue(4'd0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("e_pb_rf", 8'(pb_sel), 8'd0);

        // F: LDR R2
        issue(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_ctl("f", 1'b0);
        // G: reads R2 right after the load, with a branch -> stall, flush suppressed
        issue(4'd2, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_ctl("g_stall", 1'b1);
        check("g_flush", 8'(ifid_flush), 8'd0);
        // G held in ID: load now in MEM, no stall, branch flushes
        issue(4'd2, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_ctl("g2", 1'b0);
        check("g2_pa_mem", 8'(pa_sel), 8'd2);
        check("g2_flush", 8'(ifid_flush), 8'd1);

        // H, I: two writes of R3; I reads R6 (now in MEM behind H)
        issue(4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("h_load_wb_nostall", 8'(enable_pc), 8'd1);
        issue(4'd6, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("i_pa_mem", 8'(pa_sel), 8'd2);
        // J: EX and MEM both hold R3 -> EX priority on all three selects
        issue(4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("j_pa_ex", 8'(pa_sel), 8'd1);
        check("j_pb_ex", 8'(pb_sel), 8'd1);
        check("j_pd_ex", 8'(pd_sel), 8'd1);
        // J2: EX holds J (rf_e=0), so R3 comes from MEM
        issue(4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("j2_pa_mem", 8'(pa_sel), 8'd2);

        // K writes R15; L reads R15 -> never forwarded; L writes R7
        issue(4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(4'd15, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("l_pa_pc", 8'(pa_sel), 8'd0);
        // M: rn=R7 used, rm=R7 unused, branch without hazard
        issue(4'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("m_pa_ex", 8'(pa_sel), 8'd1);
        check("m_pb_unused", 8'(pb_sel), 8'd0);
        check("m_flush", 8'(ifid_flush), 8'd1);

        // N: LDR R8; O: store-data R8 -> stall, then reset mid-stall
        issue(4'd0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(4'd8, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ctl("o_stall", 1'b1);
        reset = 1'b1;
        #1;
        check_ctl("o_rst", 1'b0);
        check("o_rst_pa", 8'(pa_sel), 8'd0);
        check("o_rst_pd", 8'(pd_sel), 8'd0);
        // After the reset edge the scoreboard is empty
        @(negedge clk);
        reset = 1'b0;
        apply(4'd8, 4'd8, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ctl("p", 1'b0);
        check("p_pa", 8'(pa_sel), 8'd0);
        check("p_pb", 8'(pb_sel), 8'd0);
        check("p_pd", 8'(pd_sel), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forwarding_unit.md
HAZARD_FORWARDING_UNIT -- requirements
Module: hazard_forwarding_unit

Interface
REQ-001 The block SHALL use one clock and synchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
REQ-002 It SHALL have the following ID-stage inputs:
- id_rn  input  4  ID first-operand register, instr[19:16].
- id_rm  input  4  ID second-operand register, instr[3:0].
- id_rd  input  4  ID destination/store-data register, instr[15:12].
- id_use_rn / id_use_rm / id_use_rd  input  1 each  ID instruction reads that register.
- id_rf_e  input  1  ID instruction writes id_rd (post RF-enable mux).
- id_load  input  1  ID instruction is a load.
- branch_taken  input  1  branch resolved taken in ID this cycle.
REQ-003 It SHALL have the following outputs:
- pa_sel / pb_sel / pd_sel  output  2 each  operand source for the PA/PB/PD muxes: 00 RF, 01 EX, 10 MEM, 11 WB.
- enable_pc  output  1  PC load enable.
- enable_ifid  output  1  IF/ID load enable.
- cu_mux_sel  output  1  1 = control-unit multiplexer outputs a NOP.
- ifid_flush  output  1  1 = IF/ID loads a zero instruction on the next edge.

Function
REQ-004 The block SHALL keep an internal scoreboard with three entries, EX, MEM and WB, each holding {rd[3:0], rf_e, load}.
REQ-005 On every non-reset rising edge: WB<=MEM, then MEM<=EX, then EX<={id_rd, id_rf_e, id_load}; when a stall is asserted, EX<=bubble {0,0,0} instead.
REQ-006 Stall SHALL be asserted when EX.load=1, EX.rf_e=1 and EX.rd matches a source in use (id_use_rn and id_rn, id_use_rm and id_rm, or id_use_rd and id_rd).
REQ-007 While stall=1: enable_pc=0, enable_ifid=0, cu_mux_sel=1. Otherwise: enable_pc=1, enable_ifid=1, cu_mux_sel=0.
REQ-008 A stall SHALL last exactly one cycle; the inserted bubble clears the hazard in the next cycle.
REQ-009 Each select SHALL be derived independently for its source (rn->pa_sel, rm->pb_sel, rd->pd_sel) with priority EX(01) > MEM(10) > WB(11) > RF(00). A stage matches only if its rf_e=1 and its rd equals the source register.
REQ-010 Register 15 (PC) SHALL never be forwarded; the select for that source is 00.
REQ-011 If a source's use bit is 0, its select SHALL be 00.
REQ-012 Selects SHALL be computed combinationally from the current scoreboard and ID inputs, with zero-cycle latency. They remain valid during a stall; the stalled cycle's values are don't-care because EX receives a bubble.
REQ-013 ifid_flush SHALL equal branch_taken AND NOT stall; a branch that coincides with a stall is suppressed, and it re-evaluates next cycle with the instruction held in ID.
REQ-014 A load in WB or MEM SHALL NOT cause a stall; it is forwarded normally.

Reset
REQ-015 While reset=1 at a rising edge, all three scoreboard entries SHALL become bubble {0,0,0}.
REQ-016 While reset=1, the outputs SHALL be forced to: all selects 00, enable_pc=1, enable_ifid=1, cu_mux_sel=0, ifid_flush=0.
REQ-017 Reset asserted mid-stall SHALL abort the stall on that edge; the next cycle after deassertion shows no hazards.

Structure
REQ-018 A shared package pipeline_pkg SHALL hold the select encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), the constant REG_PC=4'd15, and the scoreboard entry type.
REQ-019 The three-entry shift register SHALL be a sub-module named hazard_scoreboard. Compare, priority and stall logic stays in the top module.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- ADD R1 writes, next instruction reads rn=R1 -> pa_sel=01 in that ID cycle, no stall.
- R1 written, then two unrelated instructions, then rm=R1 -> pb_sel=11. With one unrelated instruction between -> pb_sel=10.
- LDR R2 in EX, ID reads rn=R2 -> stall for 1 cycle (enable_pc=0, enable_ifid=0, cu_mux_sel=1). The next cycle has pa_sel=10 and no stall.
- EX and MEM both write R3, ID reads rn=R3 and rm=R3 -> pa_sel=pb_sel=01 (EX priority). Destination R15 with rn=15 -> pa_sel=00.
- branch_taken=1 with no hazard -> ifid_flush=1. branch_taken=1 during a load-use stall -> ifid_flush=0.
- Reset asserted during a stall -> the next cycle has enable_pc=1, all selects 00, and the scoreboard empty.
